// File: rtl/sd_dat_pkg.sv
// Shared definitions for the SD DAT-line deserializer: FSM states and bus modes.
package sd_dat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_SHIFT      = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  localparam logic BUS_1BIT = 1'b0;
  localparam logic BUS_4BIT = 1'b1;

endpackage

// File: rtl/sd_dat_shiftreg.sv
// Lane-configurable shift register with strobe counter. Presents the word
// as it will look after the current strobe so the caller can capture a
// completed word on the same edge that samples its last bit.
module sd_dat_shiftreg
  import sd_dat_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_LANES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_shift_en,
  input  logic                 i_mode,
  input  logic [MAX_LANES-1:0] i_lanes,
  output logic [WIDTH-1:0]     o_next_word,
  output logic                 o_word_done
);

  localparam int BIT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] r_shift;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] w_shifted;
  logic [BIT_W-1:0] w_last;

  // Shifted value and last-strobe index depend on the latched lane mode.
  always_comb begin
    w_shifted = {r_shift[WIDTH-2:0], i_lanes[0]};
    w_last    = BIT_W'(WIDTH - 1);
    if (i_mode == BUS_4BIT) begin
      w_shifted = {r_shift[WIDTH-MAX_LANES-1:0], i_lanes};
      w_last    = BIT_W'(WIDTH / MAX_LANES - 1);
    end
  end

  assign o_next_word = w_shifted;
  assign o_word_done = i_shift_en && (r_bit_cnt == w_last);

  // Shift on each strobe; counter wraps to zero when a word completes.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (i_shift_en) begin
      r_shift   <= w_shifted;
      r_bit_cnt <= o_word_done ? '0 : r_bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sd_dat_deserializer.sv
// SD DAT-line block receiver: waits for a start bit, assembles WIDTH-bit
// words from 1 or 4 lanes and hands them out over a valid/ready register.
module sd_dat_deserializer
  import sd_dat_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MAX_LANES   = 4,
  parameter int BLOCK_WORDS = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 bus_mode,
  input  logic                 sample_en,
  input  logic [MAX_LANES-1:0] dat_in,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int WORD_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_mode;
  logic [WORD_W-1:0] r_word_cnt;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_valid;
  logic              r_overrun;

  logic              w_start_ok;
  logic              w_start_bit;
  logic              w_shift_en;
  logic              w_word_done;
  logic              w_last_word;
  logic              w_transfer;
  logic [WIDTH-1:0]  w_next_word;

  assign w_start_ok  = (r_state == ST_IDLE) && start;
  assign w_start_bit = sample_en && ((r_mode == BUS_4BIT) ? ~|dat_in : ~dat_in[0]);
  assign w_shift_en  = (r_state == ST_SHIFT) && sample_en;
  assign w_last_word = (r_word_cnt == WORD_W'(BLOCK_WORDS - 1));
  assign w_transfer  = r_out_valid && out_ready;

  sd_dat_shiftreg #(
    .WIDTH     (WIDTH),
    .MAX_LANES (MAX_LANES)
  ) u_shiftreg (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_start_ok),
    .i_shift_en  (w_shift_en),
    .i_mode      (r_mode),
    .i_lanes     (dat_in),
    .o_next_word (w_next_word),
    .o_word_done (w_word_done)
  );

  // Next-state and status outputs of the block FSM.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        busy = 1'b1;
        if (w_start_bit) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (w_word_done && w_last_word) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register, latched lane mode and completed-word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_mode     <= BUS_1BIT;
      r_word_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_ok) begin
        r_mode     <= bus_mode;
        r_word_cnt <= '0;
      end else if (w_word_done) begin
        r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
      end
    end
  end

  // Output holding register: a completed word loads only if the slot is
  // free or being emptied this edge; otherwise it is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_start_ok) r_overrun <= 1'b0;
      if (w_word_done) begin
        if (!r_out_valid || out_ready) begin
          r_out_data  <= w_next_word;
          r_out_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_transfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sd_dat_deserializer.sv
// Randomized bench for sd_dat_deserializer with a cycle-level behavioural
// reference (bits accumulated arithmetically) plus literal anchor checks.
module tb_sd_dat_deserializer;

  localparam int W  = 32;
  localparam int ML = 4;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          bus_mode = 1'b0;
  logic          sample_en = 1'b0;
  logic [ML-1:0] dat_in = '0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          overrun;

  sd_dat_deserializer #(.WIDTH(W), .MAX_LANES(ML), .BLOCK_WORDS(BW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus_mode  (bus_mode),
    .sample_en (sample_en),
    .dat_in    (dat_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Reference model: phase 0 idle, 1 waiting for start bit, 2 shifting, 3 done.
  int          m_phase = 0;
  bit          m_mode = 0;
  int          m_bits = 0;
  logic [31:0] m_word = '0;
  int          m_wcnt = 0;
  bit          m_valid = 0;
  logic [31:0] m_data = '0;
  bit          m_ovr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", out_data, m_data);
    chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
    chk("done", 32'(done), 32'(m_phase == 3));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (done) done_cnt++;
  endtask

  task automatic model_edge(input bit st, input bit md, input bit se,
                            input logic [3:0] d, input bit rd, input bit rs);
    bit xfer;
    bit comp;
    int n;
    logic [3:0] v;
    if (rs) begin
      m_phase = 0; m_mode = 0; m_bits = 0; m_word = '0; m_wcnt = 0;
      m_valid = 0; m_data = '0; m_ovr = 0;
      return;
    end
    xfer = m_valid && rd;
    comp = 0;
    case (m_phase)
      0: if (st) begin
        m_phase = 1; m_mode = md; m_bits = 0; m_word = '0; m_wcnt = 0; m_ovr = 0;
      end
      1: if (se && (m_mode ? (d == 4'h0) : (d[0] == 1'b0))) m_phase = 2;
      2: if (se) begin
        n = m_mode ? 4 : 1;
        v = m_mode ? d : {3'b000, d[0]};
        m_word = (m_word << n) | 32'(v);
        m_bits += n;
        if (m_bits == W) begin
          comp = 1;
          m_bits = 0;
          m_wcnt++;
          if (m_wcnt == BW) m_phase = 3;
        end
      end
      default: m_phase = 0;
    endcase
    if (comp) begin
      if (!m_valid || xfer) begin
        m_data  = m_word;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
      m_word = '0;
    end else if (xfer) begin
      m_valid = 0;
    end
  endtask

  // One clock: compare outputs, drive new inputs, advance model, wait one cycle.
  task automatic step(input bit st, input bit md, input bit se,
                      input logic [3:0] d, input bit rd, input bit rs);
    check_outputs();
    start = st; bus_mode = md; sample_en = se; dat_in = d; out_ready = rd; reset = rs;
    model_edge(st, md, se, d, rd, rs);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit pick(input int pol);
    if (pol == 0) return 1'b0;
    if (pol == 1) return 1'b1;
    return 1'($urandom);
  endfunction

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) step(0, 1'($urandom), 0, 4'($urandom), rd, 0);
  endtask

  task automatic begin_block(input bit mode, input int pol);
    int g;
    step(1, mode, 0, 4'($urandom), pick(pol), 0);
    g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) begin
      // Strobes with an active lane high must not be taken as a start bit.
      step(0, 1'($urandom), 1'($urandom), mode ? 4'($urandom_range(1, 15)) : {3'($urandom), 1'b1},
           pick(pol), 0);
    end
    step(0, 1'($urandom), 1, mode ? 4'h0 : {3'($urandom), 1'b0}, pick(pol), 0);
  endtask

  task automatic send_word(input bit mode, input logic [31:0] val, input int gap_max,
                           input int pol, input int rdy_last, input bit noise, input int nstr);
    int n;
    int strobes;
    int g;
    logic [31:0] lv;
    logic [3:0] d;
    bit rd;
    n = mode ? 4 : 1;
    strobes = (nstr > 0) ? nstr : W / n;
    for (int k = 0; k < strobes; k++) begin
      g = $urandom_range(0, gap_max);
      for (int j = 0; j < g; j++)
        step(noise & 1'($urandom), 1'($urandom), 0, 4'($urandom), pick(pol), 0);
      lv = val >> (W - n * (k + 1));
      d  = mode ? lv[3:0] : {3'($urandom), lv[0]};
      rd = (k == strobes - 1 && rdy_last >= 0) ? rdy_last[0] : pick(pol);
      step(noise & 1'($urandom), 1'($urandom), 1, d, rd, 0);
    end
  endtask

  initial begin
    int d0;
    logic [31:0] w0, w1;
    bit mode;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    idle(3, 1);

    // 1-lane directed block.
    d0 = done_cnt;
    begin_block(0, 1);
    send_word(0, 32'hA5A5_0F0F, 0, 1, -1, 0, 0);
    chk("lit_1lane_w0", out_data, 32'hA5A50F0F);
    send_word(0, 32'h1234_5678, 0, 1, -1, 0, 0);
    chk("lit_1lane_w1", out_data, 32'h12345678);
    idle(4, 1);
    chk("lit_1lane_done", 32'(done_cnt - d0), 32'd1);
    chk("lit_1lane_ovr", 32'(overrun), 32'h0);

    // 4-lane directed word.
    begin_block(1, 1);
    send_word(1, 32'hDEAD_BEEF, 0, 1, -1, 0, 0);
    chk("lit_4lane_w0", out_data, 32'hDEADBEEF);
    chk("lit_4lane_valid", 32'(out_valid), 32'h1);
    send_word(1, 32'h0BAD_F00D, 1, 2, -1, 0, 0);
    idle(4, 1);

    // Consumer stalled across two completed words.
    d0 = done_cnt;
    begin_block(0, 0);
    send_word(0, 32'hCAFE_0001, 1, 0, -1, 0, 0);
    send_word(0, 32'hCAFE_0002, 1, 0, -1, 0, 0);
    idle(2, 0);
    chk("lit_stall_hold", out_data, 32'hCAFE0001);
    chk("lit_stall_ovr", 32'(overrun), 32'h1);
    chk("lit_stall_done", 32'(done_cnt - d0), 32'd1);
    idle(3, 1);

    // Completion coincides with consumption: seamless reload.
    begin_block(1, 1);
    send_word(1, 32'h1111_2222, 0, 1, -1, 0, 0);
    send_word(1, 32'h3333_4444, 2, 0, 1, 0, 0);
    chk("lit_seam_data", out_data, 32'h33334444);
    chk("lit_seam_valid", 32'(out_valid), 32'h1);
    chk("lit_seam_ovr", 32'(overrun), 32'h0);
    idle(4, 1);

    // Reset after 10 bits of a word, then a full block.
    begin_block(0, 0);
    send_word(0, 32'hFFFF_FFFF, 1, 0, -1, 0, 10);
    step(0, 0, 1, 4'hF, 0, 1);
    chk("lit_rst_data", out_data, 32'h0);
    chk("lit_rst_valid", 32'(out_valid), 32'h0);
    chk("lit_rst_busy", 32'(busy), 32'h0);
    idle(1, 1);
    begin_block(0, 1);
    send_word(0, 32'h8000_0001, 0, 1, -1, 0, 0);
    chk("lit_rst_w0", out_data, 32'h80000001);
    send_word(0, 32'h7FFF_FFFE, 0, 1, -1, 0, 0);
    chk("lit_rst_w1", out_data, 32'h7FFFFFFE);
    idle(4, 1);

    // Randomized blocks: gaps 0-3, start/bus_mode noise, random consumer.
    for (int b = 0; b < 24; b++) begin
      mode = 1'($urandom);
      w0 = $urandom;
      w1 = $urandom;
      begin_block(mode, 2);
      send_word(mode, w0, 3, 2, -1, 1, 0);
      send_word(mode, w1, 3, 2, -1, 1, 0);
      idle($urandom_range(1, 4), 1'($urandom));
    end
    idle(4, 1);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout act=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
